// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x3 keypad column scanner, frame debouncer and press FSM.
// Optional auto-repeat when KEYPAD_REPEAT_EN is defined.
//
// Ports:
//   clk, rst_n  clock, async active-low reset
//   row_n[3:0]  rows A..D, active low, asynchronous
//   col_n[2:0]  one-hot-low column drive, E..G
//   keyboard    debounced {row_n, col_n}; 7'h7F when idle
//   key_valid   one-cycle press strobe
//   key_held    high while an accepted key is down
module keypad_scanner #(
  parameter int SCAN_DIV       = 4,
  parameter int DEBOUNCE_SCANS = 3,
  parameter int REPEAT_DELAY   = 20,
  parameter int REPEAT_RATE    = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_n,
  output logic [2:0] col_n,
  output logic [6:0] keyboard,
  output logic       key_valid,
  output logic       key_held
);

  if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 1 ||
      DEBOUNCE_SCANS > 15 || REPEAT_DELAY < 1 ||
      REPEAT_RATE < 1 || REPEAT_RATE > REPEAT_DELAY)
  begin : g_bad_param
    $error("keypad_scanner: illegal parameter");
  end

  localparam int SW = $clog2(SCAN_DIV);
  localparam logic [SW-1:0] SLOT_LAST =
    SW'(SCAN_DIV - 1);
  localparam logic [3:0] DB = 4'(DEBOUNCE_SCANS);
  localparam logic [6:0] IDLE_CODE = 7'h7F;
  localparam logic [6:0] BAD_CODE  = 7'h00;

  typedef enum logic {IDLE, PRESSED} state_t;

  function automatic logic [2:0] col_code(
    input logic [1:0] idx
  );
    unique case (idx)
      2'd0:    return 3'b011;
      2'd1:    return 3'b101;
      default: return 3'b110;
    endcase
  endfunction

  function automatic logic single_low(
    input logic [3:0] r
  );
    logic [3:0] l;
    l = ~r;
    return (l != 4'd0) && ((l & (l - 4'd1)) == 4'd0);
  endfunction

  logic [3:0]    row_s1, row_s2;
  logic [SW-1:0] slot_cnt;
  logic [1:0]    col_idx, col_idx_nxt;
  logic [3:0]    cap0, cap1;
  logic [6:0]    prev_code, frame_code;
  logic [3:0]    stab_cnt, stab_nxt;
  logic [2:0]    hit;
  logic          slot_end, frame_end, stable;
  state_t        state;

  assign slot_end    = slot_cnt == SLOT_LAST;
  assign frame_end   = slot_end && col_idx == 2'd2;
  assign col_idx_nxt = (col_idx == 2'd2) ? 2'd0
                                         : col_idx + 2'd1;

  // The last column is evaluated straight from the synchronizer
  // so the frame code is ready on the frame's final cycle.
  always_comb begin
    hit = {row_s2 != 4'hF, cap1 != 4'hF, cap0 != 4'hF};
    frame_code = BAD_CODE;
    unique case (1'b1)
      hit == 3'b000:
        frame_code = IDLE_CODE;
      hit == 3'b001 && single_low(cap0):
        frame_code = {cap0, 3'b011};
      hit == 3'b010 && single_low(cap1):
        frame_code = {cap1, 3'b101};
      hit == 3'b100 && single_low(row_s2):
        frame_code = {row_s2, 3'b110};
      default:
        frame_code = BAD_CODE;
    endcase
  end

  always_comb begin
    stab_nxt = 4'd1;
    if (frame_code == prev_code)
      stab_nxt = (stab_cnt >= DB) ? DB
                                  : stab_cnt + 4'd1;
  end

  assign stable = stab_nxt == DB;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_s1    <= 4'hF;
      row_s2    <= 4'hF;
      slot_cnt  <= '0;
      col_idx   <= 2'd0;
      col_n     <= 3'b011;
      cap0      <= 4'hF;
      cap1      <= 4'hF;
      prev_code <= IDLE_CODE;
      stab_cnt  <= 4'd0;
    end else begin
      row_s1 <= row_n;
      row_s2 <= row_s1;
      if (slot_end) begin
        slot_cnt <= '0;
        col_idx  <= col_idx_nxt;
        col_n    <= col_code(col_idx_nxt);
        if (col_idx == 2'd0) cap0 <= row_s2;
        if (col_idx == 2'd1) cap1 <= row_s2;
      end else begin
        slot_cnt <= slot_cnt + 1'b1;
      end
      if (frame_end) begin
        prev_code <= frame_code;
        stab_cnt  <= stab_nxt;
      end
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY + 1);
  localparam logic [RW-1:0] RPT_HIT = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] RPT_RELOAD =
    RW'(REPEAT_DELAY - REPEAT_RATE);
  logic [RW-1:0] rpt_cnt;
  logic [RW-1:0] rpt_nxt;
  assign rpt_nxt = rpt_cnt + 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      keyboard  <= IDLE_CODE;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rpt_cnt   <= '0;
`endif
    end else begin
      key_valid <= 1'b0;
      if (frame_end) begin
        unique case (state)
          IDLE: begin
            if (stable && frame_code != IDLE_CODE &&
                frame_code != BAD_CODE) begin
              keyboard  <= frame_code;
              key_valid <= 1'b1;
              key_held  <= 1'b1;
              state     <= PRESSED;
`ifdef KEYPAD_REPEAT_EN
              rpt_cnt   <= '0;
`endif
            end
          end
          PRESSED: begin
            if (stable && frame_code == IDLE_CODE) begin
              keyboard <= IDLE_CODE;
              key_held <= 1'b0;
              state    <= IDLE;
`ifdef KEYPAD_REPEAT_EN
              rpt_cnt  <= '0;
`endif
            end
`ifdef KEYPAD_REPEAT_EN
            // Reload keeps later repeats REPEAT_RATE apart.
            else if (frame_code == keyboard &&
                     frame_code == prev_code) begin
              if (rpt_nxt == RPT_HIT) begin
                key_valid <= 1'b1;
                rpt_cnt   <= RPT_RELOAD;
              end else begin
                rpt_cnt <= rpt_nxt;
              end
            end else begin
              rpt_cnt <= '0;
            end
`endif
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed vector bench for keypad_scanner.
// Keypad is modelled as a switch matrix driven by col_n.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] row_n;
  logic [2:0] col_n;
  logic [6:0] keyboard;
  logic       key_valid;
  logic       key_held;
  logic [11:0] keys = '0;

  int checks = 0;
  int failures = 0;
  int viol = 0;
  logic kv_d = 1'b0;

  // key index: 0..11 = 1 2 3 4 5 6 7 8 9 * 0 #
  localparam logic [11:0] K1 = 12'h001;
  localparam logic [11:0] K5 = 12'h010;
  localparam logic [11:0] K8 = 12'h080;
  localparam logic [11:0] K9 = 12'h100;
  localparam logic [11:0] KS = 12'h200;
  localparam logic [11:0] K0 = 12'h400;
  localparam logic [11:0] KH = 12'h800;

  always #5 clk = ~clk;

  keypad_scanner dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row_n     (row_n),
    .col_n     (col_n),
    .keyboard  (keyboard),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always_comb begin
    row_n = 4'hF;
    for (int k = 0; k < 12; k++)
      if (keys[k] && !col_n[2 - (k % 3)])
        row_n[3 - (k / 3)] = 1'b0;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (key_valid && !key_held) viol++;
      if (key_valid && kv_d) viol++;
    end
    kv_d = key_valid;
  end

  typedef struct {
    logic [11:0] keys;
    int          frames;
    logic [6:0]  kb;
    int          pulses;
    logic        held;
  } vec_t;

  vec_t tv[13];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h",
               name, act, exp);
    end
  endtask

  task automatic run(input int n, output int p);
    p = 0;
    repeat (n) begin
      @(negedge clk);
      if (key_valid) p++;
    end
  endtask

  initial begin
    int p;
    int exp_rpt;
    logic [2:0] ce;

    tv[0]  = '{12'h000, 8, 7'h7F, 0, 1'b0};
    tv[1]  = '{K5,      6, 7'h5D, 1, 1'b1};
    tv[2]  = '{12'h000, 4, 7'h7F, 0, 1'b0};
    tv[3]  = '{K8,      4, 7'h6D, 1, 1'b1};
    tv[4]  = '{K8 | K0, 6, 7'h6D, 0, 1'b1};
    tv[5]  = '{12'h000, 4, 7'h7F, 0, 1'b0};
    tv[6]  = '{K1 | K9, 6, 7'h7F, 0, 1'b0};
    tv[7]  = '{K1,      4, 7'h3B, 1, 1'b1};
    tv[8]  = '{12'h000, 4, 7'h7F, 0, 1'b0};
    tv[9]  = '{KH,      4, 7'h76, 1, 1'b1};
    tv[10] = '{12'h000, 4, 7'h7F, 0, 1'b0};
    tv[11] = '{KS,      4, 7'h73, 1, 1'b1};
    tv[12] = '{12'h000, 4, 7'h7F, 0, 1'b0};

    // reset state, released on a negedge = frame start
    repeat (2) @(negedge clk);
    chk("rst_col", 32'(col_n), 32'(3'b011));
    chk("rst_kb", 32'(keyboard), 32'h7F);
    chk("rst_kv", 32'(key_valid), 0);
    chk("rst_held", 32'(key_held), 0);
    rst_n = 1'b1;

    // column rotation over two frames
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      case ((k / 4) % 3)
        0:       ce = 3'b011;
        1:       ce = 3'b101;
        default: ce = 3'b110;
      endcase
      chk("col_seq", 32'(col_n), 32'(ce));
    end

    for (int i = 0; i < 13; i++) begin
      keys = tv[i].keys;
      run(tv[i].frames * 12, p);
      chk($sformatf("v%0d_kb", i),
          32'(keyboard), 32'(tv[i].kb));
      chk($sformatf("v%0d_pulses", i),
          32'(p), 32'(tv[i].pulses));
      chk($sformatf("v%0d_held", i),
          32'(key_held), 32'(tv[i].held));
    end

    // exact press latency and release timing
    keys = K5;
    for (int t = 1; t <= 36; t++) begin
      @(negedge clk);
      if (t == 35) chk("lat_early", 32'(key_valid), 0);
      if (t == 36) chk("lat_hit", 32'(key_valid), 1);
    end
    chk("lat_kb", 32'(keyboard), 32'h5D);
    keys = '0;
    for (int t = 1; t <= 37; t++) begin
      @(negedge clk);
      if (t == 1)  chk("lat_off", 32'(key_valid), 0);
      if (t == 35) chk("rel_early", 32'(key_held), 1);
      if (t == 36) chk("rel_held", 32'(key_held), 0);
      if (t == 36) chk("rel_kb", 32'(keyboard), 32'h7F);
    end
    repeat (11) @(negedge clk);

    // bouncing key 1, then stable
    p = 0;
    for (int t = 0; t < 48; t++) begin
      keys = ((t / 7) % 2 == 0) ? K1 : 12'h000;
      @(negedge clk);
      if (key_valid) p++;
    end
    chk("bounce_quiet", 32'(p), 0);
    keys = K1;
    run(36, p);
    chk("bounce_pulse", 32'(p), 1);
    chk("bounce_kb", 32'(keyboard), 32'h3B);
    keys = '0;
    run(48, p);
    chk("bounce_rel", 32'(key_held), 0);

    // reset while pressed
    keys = K5;
    run(42, p);
    chk("pre_rst_held", 32'(key_held), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_kb", 32'(keyboard), 32'h7F);
    chk("arst_held", 32'(key_held), 0);
    chk("arst_col", 32'(col_n), 32'(3'b011));
    @(negedge clk);
    rst_n = 1'b1;
    run(35, p);
    chk("post_rst_quiet", 32'(p), 0);
    @(negedge clk);
    chk("post_rst_kv", 32'(key_valid), 1);
    chk("post_rst_kb", 32'(keyboard), 32'h5D);

    // long hold: auto-repeat only in the repeat build
`ifdef KEYPAD_REPEAT_EN
    exp_rpt = 4;
`else
    exp_rpt = 0;
`endif
    run(35 * 12, p);
    chk("hold_repeats", 32'(p), 32'(exp_rpt));
    chk("hold_kb", 32'(keyboard), 32'h5D);
    keys = '0;
    run(48, p);
    chk("hold_rel", 32'(key_held), 0);
    chk("hold_rel_pulses", 32'(p), 0);

    chk("invariants", 32'(viol), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Column-scanning front end for the 4x3 telephone keypad. Drives the three column lines one at a time and samples the four row lines. Each press is debounced over whole scan frames, then presented as the 7-bit active-low code {A,B,C,D,E,F,G} consumed by the keypad number decoder directly downstream. It also emits a one-cycle press strobe and a held level so the digit/FSM logic can register each key exactly once.

Parameters:
SCAN_DIV, 4, clock cycles each column is driven; legal minimum 4 (2-flop sync plus settle).
DEBOUNCE_SCANS, 3, consecutive identical frames needed to accept a press or a release; range 1..15.
REPEAT_DELAY, 20, frames a key is held before the first auto-repeat; used only with KEYPAD_REPEAT_EN.
REPEAT_RATE, 5, frames between auto-repeats; used only with KEYPAD_REPEAT_EN.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
row_n  input  4  keypad rows, active low; [3]=A, [2]=B, [1]=C, [0]=D; asynchronous to clk
col_n  output  3  keypad column drive, one-hot low; [2]=E, [1]=F, [0]=G
keyboard  output  7  debounced code {row_n, col_n}; 7'b1111111 when no key is accepted
key_valid  output  1  one-cycle strobe when a press is accepted
key_held  output  1  high while an accepted key has not been released

Behaviour:
- Reset (async, rst_n=0): col_n=3'b011, keyboard=7'h7F, key_valid=0, key_held=0. Sync flops load 4'hF, all counters load 0, FSM enters IDLE. Asserting rst_n mid-press aborts immediately; no key_valid is emitted on release of reset.
- row_n passes through a 2-flop synchronizer; all logic uses the synchronized value.
- Column counter: slot counter counts 0..SCAN_DIV-1 and column index counts 0..2, wrapping to 0. Order E(col_n=011), F(101), G(110). col_n is registered from the column index.
- Sample point: the last cycle of each slot. At that cycle the synchronized row is captured for the current column.
- Frame: three slots, 3*SCAN_DIV cycles. At frame end the frame code is formed:
  - no row low in any column -> 7'h7F (idle);
  - exactly one column with exactly one row low -> {rows, col_n of that column};
  - anything else (multi-key or ghost) -> 7'h00 (invalid).
- Stability counter: saturates at DEBOUNCE_SCANS. Resets to 1 when the frame code differs from the previous frame code. Otherwise it increments.
- FSM IDLE:
  - keyboard=7'h7F.
  - A valid single-key frame code with stable count reaching DEBOUNCE_SCANS -> keyboard latches that code, key_valid=1 for exactly one cycle (the cycle after frame end), key_held=1, go to PRESSED.
  - Idle and invalid codes never leave IDLE.
- FSM PRESSED:
  - keyboard holds the latched code.
  - Frame code 7'h7F stable for DEBOUNCE_SCANS frames -> keyboard=7'h7F, key_held=0, go to IDLE. No strobe on release.
  - Any other code, including a different key or multi-key, is ignored and restarts the release count. A new key requires a full release first.
- Latency: a clean press present from the start of a frame produces key_valid DEBOUNCE_SCANS*3*SCAN_DIV + 1 cycles after frame start (37 cycles with defaults). A press starting mid-frame adds up to one extra frame.
- key_valid and key_held are never both asserted in IDLE. key_valid is never high for two consecutive cycles.

Optional Feature:
KEYPAD_REPEAT_EN:
- Defined: in PRESSED, a frame counter starts at acceptance. key_valid re-pulses for one cycle at frame REPEAT_DELAY, then every REPEAT_RATE frames while the same code remains stable. The counter clears on release.
- Undefined: exactly one key_valid per press. The repeat counter and REPEAT_* parameters are unused and synthesize away.

Test Plan:
1. Reset, then idle rows (row_n=4'hF) for 10 frames -> col_n cycles 011/101/110 every 4 cycles; keyboard=7'h7F, key_valid=0, key_held=0 throughout.
2. Hold key '5' (row B low while col F driven) for 6 frames -> one key_valid pulse, keyboard=7'b1011101, key_held=1; decoder output 5.
3. Key '1' bouncing (row A toggles every 7 cycles) for 4 frames, then stable -> no key_valid during bounce; single strobe 3 frames after bouncing stops, keyboard=7'b0111011.
4. Press '8', then release -> keyboard returns to 7'h7F and key_held=0 exactly 3 idle frames later. Pressing '0' while '8' is held -> no second strobe, keyboard stays 7'b1101101.
5. Keys '1' and '9' pressed together for 6 frames -> no key_valid, keyboard=7'h7F. Releasing '9' -> '1' accepted after 3 frames.
6. Drive rst_n low mid-PRESSED for one cycle -> outputs reset asynchronously. With the key still down after reset, a fresh strobe follows after 3 stable frames. With KEYPAD_REPEAT_EN, holding the key for 35 frames -> strobes at acceptance, +20, +25, +30, +35 frames.
